// File: rtl/secuenciador_booth.sv
// Sequencer for the signed multiplier: operand capture, Booth multiply, sign/magnitude split, BCD conversion, display load.
// Latency pb_pulse->mult_valid and mult_done->bcd_valid is one cycle; pb_pulse while busy is dropped, waits are timeout-supervised.
module secuenciador_booth #(
    parameter int W              = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             pb_pulse,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    output logic             mult_valid,
    output logic [W-1:0]     mult_a,
    output logic [W-1:0]     mult_b,
    input  logic             mult_done,
    input  logic [2*W-1:0]   mult_p,
    output logic             bcd_valid,
    output logic [2*W-2:0]   bcd_bin,
    input  logic             bcd_done,
    input  logic [19:0]      bcd_code,
    output logic [20:0]      disp_code,
    output logic             busy,
    output logic             error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, M_START, M_WAIT, B_START, B_WAIT, ERR
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            sign_q;
    logic            mult_valid_q, bcd_valid_q, busy_q, error_q;
    logic [W-1:0]    mult_a_q, mult_b_q;
    logic [2*W-2:0]  bcd_bin_q;
    logic [20:0]     disp_code_q;
    logic [2*W-2:0]  mag_d;

    // |p| always fits in 2W-1 bits because the most negative product is never reached.
    assign mag_d = (2*W-1)'(mult_p[2*W-1] ? -mult_p : mult_p);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            mult_valid_q <= 1'b0;
            bcd_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            bcd_bin_q    <= '0;
            disp_code_q  <= '0;
        end else begin
            mult_valid_q <= 1'b0;
            bcd_valid_q  <= 1'b0;
            case (state_q)
                IDLE, ERR: begin
                    if (pb_pulse) begin
                        mult_a_q     <= op_a;
                        mult_b_q     <= op_b;
                        error_q      <= 1'b0;
                        mult_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= M_START;
                    end
                end
                M_START: begin
                    cnt_q   <= '0;
                    state_q <= M_WAIT;
                end
                M_WAIT: begin
                    if (mult_done) begin
                        sign_q      <= mult_p[2*W-1];
                        bcd_bin_q   <= mag_d;
                        bcd_valid_q <= 1'b1;
                        state_q     <= B_START;
                    end else if (cnt_q == CNT_LAST) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                B_START: begin
                    cnt_q   <= '0;
                    state_q <= B_WAIT;
                end
                B_WAIT: begin
                    if (bcd_done) begin
                        disp_code_q <= {sign_q, bcd_code};
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mult_valid = mult_valid_q;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign bcd_valid  = bcd_valid_q;
    assign bcd_bin    = bcd_bin_q;
    assign disp_code  = disp_code_q;
    assign busy       = busy_q;
    assign error      = error_q;

endmodule

// File: tb/tb_secuenciador_booth.sv
// Directed bench for secuenciador_booth: hand-computed products, magnitudes and display codes.
module tb_secuenciador_booth;

    localparam int W  = 8;
    localparam int TO = 256;

    logic          CLK100MHZ = 1'b0;
    logic          reset = 1'b1;
    logic          pb_pulse = 1'b0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic          mult_valid;
    logic [W-1:0]  mult_a, mult_b;
    logic          mult_done = 1'b0;
    logic [15:0]   mult_p = '0;
    logic          bcd_valid;
    logic [14:0]   bcd_bin;
    logic          bcd_done = 1'b0;
    logic [19:0]   bcd_code = '0;
    logic [20:0]   disp_code;
    logic          busy, error;

    int errors = 0;
    int checks = 0;

    secuenciador_booth #(.W(W), .TIMEOUT_CYCLES(TO)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .pb_pulse  (pb_pulse),
        .op_a      (op_a),
        .op_b      (op_b),
        .mult_valid(mult_valid),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_done (mult_done),
        .mult_p    (mult_p),
        .bcd_valid (bcd_valid),
        .bcd_bin   (bcd_bin),
        .bcd_done  (bcd_done),
        .bcd_code  (bcd_code),
        .disp_code (disp_code),
        .busy      (busy),
        .error     (error)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mult_valid"}, 32'(mult_valid), 0);
        chk({tag, ".bcd_valid"},  32'(bcd_valid), 0);
        chk({tag, ".mult_a"},     32'(mult_a), 0);
        chk({tag, ".mult_b"},     32'(mult_b), 0);
        chk({tag, ".bcd_bin"},    32'(bcd_bin), 0);
        chk({tag, ".disp_code"},  32'(disp_code), 0);
        chk({tag, ".busy"},       32'(busy), 0);
        chk({tag, ".error"},      32'(error), 0);
    endtask

    // Full transaction; multiplier answers after wait_cyc cycles in M_WAIT.
    task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] p, input logic [19:0] code,
                           input logic [14:0] exp_bin, input logic [20:0] exp_disp,
                           input int wait_cyc);
        op_a = a; op_b = b; pb_pulse = 1'b1;
        tick();
        pb_pulse = 1'b0;
        chk({tag, ".mv_hi"},  32'(mult_valid), 1);
        chk({tag, ".mult_a"}, 32'(mult_a), 32'(a));
        chk({tag, ".mult_b"}, 32'(mult_b), 32'(b));
        chk({tag, ".busy"},   32'(busy), 1);
        tick();
        chk({tag, ".mv_lo"},  32'(mult_valid), 0);
        repeat (wait_cyc) tick();
        mult_done = 1'b1; mult_p = p;
        tick();
        mult_done = 1'b0; mult_p = 16'hA5A5;
        chk({tag, ".bv_hi"},   32'(bcd_valid), 1);
        chk({tag, ".mv_off"},  32'(mult_valid), 0);
        chk({tag, ".bcd_bin"}, 32'(bcd_bin), 32'(exp_bin));
        tick();
        chk({tag, ".bv_lo"},    32'(bcd_valid), 0);
        chk({tag, ".bin_hold"}, 32'(bcd_bin), 32'(exp_bin));
        chk({tag, ".busy_w"},   32'(busy), 1);
        bcd_done = 1'b1; bcd_code = code;
        tick();
        bcd_done = 1'b0; bcd_code = 20'h0;
        chk({tag, ".disp"},   32'(disp_code), 32'(exp_disp));
        chk({tag, ".busy_0"}, 32'(busy), 0);
        chk({tag, ".err_0"},  32'(error), 0);
    endtask

    initial begin
        reset = 1'b1;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        run_txn("p5x3",   8'd5,   8'd3,   16'd15,   20'h00015, 15'd15,    21'h000015, 10);
        run_txn("m7x6",   8'hF9,  8'd6,   16'hFFD6, 20'h00042, 15'd42,    21'h100042, 3);
        run_txn("m128sq", 8'h80,  8'h80,  16'h4000, 20'h16384, 15'd16384, 21'h016384, 1);
        run_txn("m7x6b",  8'hF9,  8'd6,   16'hFFD6, 20'h00042, 15'd42,    21'h100042, 0);

        // Timeout in M_WAIT: error exactly TO edges after M_WAIT entry.
        op_a = 8'd2; op_b = 8'd2; pb_pulse = 1'b1;
        tick();
        pb_pulse = 1'b0;
        tick();
        repeat (TO - 1) tick();
        chk("to.busy_pre",  32'(busy), 1);
        chk("to.err_pre",   32'(error), 0);
        tick();
        chk("to.err",       32'(error), 1);
        chk("to.busy",      32'(busy), 0);
        chk("to.disp_hold", 32'(disp_code), 32'h100042);
        mult_done = 1'b1; mult_p = 16'd4;
        tick();
        mult_done = 1'b0;
        chk("to.late_done_bv", 32'(bcd_valid), 0);
        chk("to.err_sticky",   32'(error), 1);
        op_a = 8'd0; op_b = 8'hFB; pb_pulse = 1'b1;
        tick();
        pb_pulse = 1'b0;
        chk("to.err_clr", 32'(error), 0);
        chk("to.mv",      32'(mult_valid), 1);
        tick();
        mult_done = 1'b1; mult_p = 16'h0000;
        tick();
        mult_done = 1'b0;
        chk("zero.bin", 32'(bcd_bin), 0);
        tick();
        bcd_done = 1'b1; bcd_code = 20'h00000;
        tick();
        bcd_done = 1'b0;
        chk("zero.disp", 32'(disp_code), 0);
        chk("zero.busy", 32'(busy), 0);

        // pb_pulse while busy is ignored, including together with mult_done.
        op_a = 8'd5; op_b = 8'd3; pb_pulse = 1'b1;
        tick();
        pb_pulse = 1'b0;
        tick();
        op_a = 8'd9; op_b = 8'd9; pb_pulse = 1'b1;
        tick();
        pb_pulse = 1'b0;
        chk("ign.mv",     32'(mult_valid), 0);
        chk("ign.mult_a", 32'(mult_a), 5);
        chk("ign.mult_b", 32'(mult_b), 3);
        pb_pulse = 1'b1; mult_done = 1'b1; mult_p = 16'd15;
        tick();
        pb_pulse = 1'b0; mult_done = 1'b0;
        chk("ign.bv",     32'(bcd_valid), 1);
        chk("ign.mv2",    32'(mult_valid), 0);
        chk("ign.bin",    32'(bcd_bin), 15);
        chk("ign.mult_a2", 32'(mult_a), 5);
        tick();
        bcd_done = 1'b1; bcd_code = 20'h00015;
        tick();
        bcd_done = 1'b0;
        chk("ign.disp", 32'(disp_code), 32'h000015);

        // Reset during B_WAIT, then a late bcd_done.
        op_a = 8'hF9; op_b = 8'd6; pb_pulse = 1'b1;
        tick();
        pb_pulse = 1'b0;
        tick();
        mult_done = 1'b1; mult_p = 16'hFFD6;
        tick();
        mult_done = 1'b0;
        tick();
        chk("rst.in_bwait", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("rst_mid");
        bcd_done = 1'b1; bcd_code = 20'h00042;
        tick();
        bcd_done = 1'b0;
        chk("rst.late_disp", 32'(disp_code), 0);
        chk("rst.late_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/secuenciador_booth.md
Name: secuenciador_booth

Overview:
Central controller for the signed-multiplier datapath. It turns a debounced push-button pulse into a single ordered transaction:
- capture operands
- start the Booth multiplier and wait for its done
- convert the signed product to sign plus magnitude
- start the binary-to-BCD converter and wait for its done
- load the display code register

It sits between the input-reading/debounce block and the multiplier, BCD and 7-segment blocks. It replaces ad-hoc valid/done glue, adds timeout supervision, and corrects negative-product display.

Parameters:
- W, 8, operand width in bits (product is 2W).
- TIMEOUT_CYCLES, 256, maximum cycles allowed in any wait state before error.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- pb_pulse  input  1  one-cycle debounced "compute" request.
- op_a  input  W  multiplier operand, two's complement.
- op_b  input  W  multiplicand operand, two's complement.
- mult_valid  output  1  one-cycle start pulse to multiplier.
- mult_a  output  W  registered operand A to multiplier.
- mult_b  output  W  registered operand B to multiplier.
- mult_done  input  1  multiplier completion pulse.
- mult_p  input  2W  signed product, valid when mult_done=1.
- bcd_valid  output  1  one-cycle start pulse to BCD converter.
- bcd_bin  output  2W-1  product magnitude to BCD converter.
- bcd_done  input  1  BCD completion pulse.
- bcd_code  input  20  5-digit BCD result, valid when bcd_done=1.
- disp_code  output  21  {sign, bcd_code} to display.
- busy  output  1  transaction in progress.
- error  output  1  timeout occurred (sticky).

Behaviour:
- Reset (dominant over every other input, in any state): state=IDLE; all outputs 0; timeout counter 0.
- States: IDLE, M_START, M_WAIT, B_START, B_WAIT, ERR.
- busy=1 in M_START, M_WAIT, B_START, B_WAIT; 0 in IDLE and ERR.
- IDLE / ERR, pb_pulse=1 at edge t:
  - mult_a<=op_a, mult_b<=op_b; error<=0; state->M_START.
  - mult_valid=1 for exactly the cycle after edge t.
- M_START: next edge -> M_WAIT; counter cleared.
- M_WAIT:
  - mult_done=1 at edge t: sign<=mult_p[2W-1]; bcd_bin<=|mult_p| (two's-complement negate when negative, low 2W-1 bits); state->B_START. bcd_bin is stable from edge t onward.
  - Else counter++; counter reaching TIMEOUT_CYCLES-1 -> ERR, error<=1.
- B_START: bcd_valid=1 for that single cycle; next edge -> B_WAIT; counter cleared.
- B_WAIT:
  - bcd_done=1 at edge u: disp_code<={sign, bcd_code}; state->IDLE (busy=0 after edge u).
  - Timeout handled as in M_WAIT.
- ERR: disp_code holds last good value; error stays 1 until next pb_pulse or reset.
- Magnitude range (W=8): product in [-16256, 16384]; |p| ≤ 16384 fits 15 bits with no overflow. Zero product gives sign=0.
- pb_pulse while busy=1: ignored, no queuing; operands and outputs unaffected.
- mult_done / bcd_done outside their wait state: ignored.
- mult_done and pb_pulse in the same cycle: only mult_done acts, since the block is busy.
- mult_valid and bcd_valid are never high in the same cycle; each is high ≤1 cycle per transaction.
- Latency:
  - pb_pulse → mult_valid: 1 cycle.
  - mult_done → bcd_valid: 1 cycle.
  - bcd_done → disp_code: same edge.
- Reset mid-transaction: abort immediately, all outputs 0; a late done after reset is ignored.

Test Plan:
- op_a=5, op_b=3, pb_pulse; model mult_done after 10 cycles with 15 and bcd_done with 0x00015 → mult_valid 1 cycle after pulse, bcd_bin=15, disp_code=0x000015, busy 0 after bcd_done edge.
- op_a=-7 (0xF9), op_b=6; mult_p=0xFFD6 → bcd_bin=42, sign=1; with bcd_code=0x00042 → disp_code=0x100042.
- op_a=op_b=-128; mult_p=0x4000 → bcd_bin=16384, sign=0. Also op_a=0, op_b=-5 → bcd_bin=0, sign=0.
- mult_done never asserted → error=1 and busy=0 exactly TIMEOUT_CYCLES after M_WAIT entry; disp_code unchanged. Next pb_pulse clears error and issues mult_valid.
- Second pb_pulse during M_WAIT with different operands → ignored: mult_a/mult_b unchanged, no extra mult_valid, result from first operands.
- reset asserted in B_WAIT, then bcd_done pulsed → all outputs 0, state IDLE, disp_code stays 0.
